// File: rtl/rv_boot_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv_boot_pkg
// Brief  : Shared types and constants for the rv_boot_loader block.
//          RV_BOOT_CHECKSUM_EN adds the S_CHK state.
// Rev    : 1.0 - initial release
// ============================================================================
package rv_boot_pkg;

  localparam int unsigned C_IMEM_DEPTH = 256;

  typedef logic [15:0] len_t;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
`ifdef RV_BOOT_CHECKSUM_EN
    S_CHK    = 3'd3,
`endif
    S_RUN    = 3'd4,
    S_ERR    = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rv_boot_if.sv
`default_nettype none
// ============================================================================
// Module : rv_boot_if
// Brief  : Boot byte stream input plus instruction-memory / core-control outputs.
// Rev    : 1.0 - initial release
// ============================================================================
interface rv_boot_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid_i;
  logic [7:0]        rx_data_i;
  logic              rx_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              core_reset_o;
  logic              boot_done_o;
  logic              boot_err_o;

  modport master (
    output rx_valid_i, rx_data_i,
    input  rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
           core_reset_o, boot_done_o, boot_err_o
  );

  modport slave (
    input  rx_valid_i, rx_data_i,
    output rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
           core_reset_o, boot_done_o, boot_err_o
  );
endinterface
`default_nettype wire

// File: rtl/rv_boot_word_asm.sv
`default_nettype none
// ============================================================================
// Module : rv_boot_word_asm
// Brief  : Little-endian byte-to-word assembler; pulses o_word_rdy the cycle
//          after the 4th byte, with o_word held until the next completion.
// Rev    : 1.0 - initial release
// ============================================================================
module rv_boot_word_asm (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        i_valid,
  input  wire logic [7:0]  i_byte,
  output logic      [31:0] o_word,
  output logic             o_word_rdy,
  output logic             o_last_byte
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;
  logic [31:0] r_word;
  logic        r_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
      r_word  <= 32'd0;
      r_rdy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (i_valid) begin
        r_cnt <= r_cnt + 2'd1;
        case (r_cnt)
          2'd0: r_shift[7:0]   <= i_byte;
          2'd1: r_shift[15:8]  <= i_byte;
          2'd2: r_shift[23:16] <= i_byte;
          default: begin
            // Separate output register keeps the strobe-cycle word stable
            // while the next word's first byte is already being collected.
            r_word <= {i_byte, r_shift};
            r_rdy  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_word      = r_word;
  assign o_word_rdy  = r_rdy;
  assign o_last_byte = (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/rv_boot_loader.sv
`default_nettype none
// ============================================================================
// Module : rv_boot_loader
// Brief  : Loads a length-prefixed boot image into IMEM, then releases the core.
//          Define RV_BOOT_CHECKSUM_EN for a trailing mod-256 data checksum.
// Rev    : 1.0 - initial release
// ============================================================================
module rv_boot_loader
  import rv_boot_pkg::*;
#(
  parameter int IMEM_DEPTH = C_IMEM_DEPTH
) (
  input  wire logic clk,
  input  wire logic reset,
  rv_boot_if.slave  bus
);

  localparam int ADDR_W = $clog2(IMEM_DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  len_t              r_len;
  logic [ADDR_W-1:0] r_wcnt;
  logic              r_img_full;
  logic              r_rx_ready;
  logic              r_core_reset;
  logic              r_done;
  logic              r_err;

  logic              w_acc;
  logic              w_data_acc;
  len_t              w_len_full;
  logic              w_last_word;
  logic              w_word_rdy;
  logic              w_asm_last;
  logic [31:0]       w_word;

  assign w_acc       = bus.rx_valid_i & r_rx_ready;
  // Once the final data byte is in, a byte seen during the last strobe cycle
  // is not image data (it is the checksum when that feature is built).
  assign w_data_acc  = w_acc & (r_state == S_DATA) & ~r_img_full;
  assign w_len_full  = {bus.rx_data_i, r_len[7:0]};
  assign w_last_word = (len_t'(r_wcnt) == (r_len - 16'd1));

`ifdef RV_BOOT_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       w_sum_ok;

  assign w_sum_ok = (bus.rx_data_i == r_sum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum <= 8'd0;
    end else if (w_data_acc) begin
      r_sum <= r_sum + bus.rx_data_i;
    end
  end
`endif

  rv_boot_word_asm u_word_asm (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (w_data_acc),
    .i_byte      (bus.rx_data_i),
    .o_word      (w_word),
    .o_word_rdy  (w_word_rdy),
    .o_last_byte (w_asm_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LEN_LO: begin
        if (w_acc) w_state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_acc) begin
          if ((w_len_full == '0) || (int'(w_len_full) > IMEM_DEPTH))
            w_state_nxt = S_ERR;
          else
            w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_word_rdy && w_last_word) begin
`ifdef RV_BOOT_CHECKSUM_EN
          if (w_acc)
            w_state_nxt = w_sum_ok ? S_RUN : S_ERR;
          else
            w_state_nxt = S_CHK;
`else
          w_state_nxt = S_RUN;
`endif
        end
      end
`ifdef RV_BOOT_CHECKSUM_EN
      S_CHK: begin
        if (w_acc) w_state_nxt = w_sum_ok ? S_RUN : S_ERR;
      end
`endif
      S_RUN:   w_state_nxt = S_RUN;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_LEN_LO;
      r_len        <= '0;
      r_wcnt       <= '0;
      r_img_full   <= 1'b0;
      r_rx_ready   <= 1'b0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_LEN_LO) && w_acc) r_len[7:0]  <= bus.rx_data_i;
      if ((r_state == S_LEN_HI) && w_acc) r_len[15:8] <= bus.rx_data_i;
      if (w_word_rdy) r_wcnt <= r_wcnt + 1'b1;
      if (w_data_acc && w_asm_last && w_last_word) r_img_full <= 1'b1;
      // Status outputs follow the next state so they change with the state.
      r_rx_ready   <= (w_state_nxt != S_RUN) && (w_state_nxt != S_ERR);
      r_core_reset <= (w_state_nxt != S_RUN);
      r_done       <= (w_state_nxt == S_RUN);
      r_err        <= (w_state_nxt == S_ERR);
    end
  end

  assign bus.rx_ready_o   = r_rx_ready;
  assign bus.imem_we_o    = w_word_rdy;
  assign bus.imem_addr_o  = r_wcnt;
  assign bus.imem_wdata_o = w_word;
  assign bus.core_reset_o = r_core_reset;
  assign bus.boot_done_o  = r_done;
  assign bus.boot_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rv_boot_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_rv_boot_loader
// Brief  : Randomized self-checking bench for rv_boot_loader (IMEM_DEPTH=256).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_rv_boot_loader;

  typedef logic [7:0] u8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rv_boot_if #(.ADDR_W(8)) bus();

  rv_boot_loader #(.IMEM_DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor
  int          cyc = 0;
  logic [39:0] wr_q[$];
  int          we_cyc_q[$];
  int          fall_cyc = -1;
  bit          prev_we = 1'b0;
  bit          prev_cr = 1'b1;
  bit          dbl_we  = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.imem_we_o === 1'b1) begin
      wr_q.push_back({bus.imem_addr_o, bus.imem_wdata_o});
      we_cyc_q.push_back(cyc);
      if (prev_we) dbl_we = 1'b1;
    end
    if (prev_cr && (bus.core_reset_o === 1'b0)) fall_cyc = cyc;
    prev_we = (bus.imem_we_o === 1'b1);
    prev_cr = (bus.core_reset_o !== 1'b0);
  end

  // Reference model: decode the stream from the format rules
  logic [31:0] exp_w[$];
  bit          exp_run;
  bit          exp_err;

  task automatic model(input u8 s[$]);
    int n;
    u8  sum;
    exp_w.delete();
    exp_run = 1'b0;
    exp_err = 1'b0;
    sum     = 8'd0;
    n = int'(s[0]) + 256 * int'(s[1]);
    if (n == 0 || n > 256) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      exp_w.push_back({s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]});
      for (int j = 0; j < 4; j++) sum = sum + s[2+4*k+j];
    end
`ifdef RV_BOOT_CHECKSUM_EN
    if (s.size() > 2 + 4*n && s[2+4*n] == sum) exp_run = 1'b1;
    else exp_err = 1'b1;
`else
    exp_run = 1'b1;
`endif
  endtask

  u8 img[$];

  task automatic make_img(input int n);
    u8 sum;
    u8 b;
    sum = 8'd0;
    img.delete();
    img.push_back(u8'(n & 255));
    img.push_back(u8'(n >> 8));
    for (int i = 0; i < 4*n; i++) begin
      b = u8'($urandom_range(255, 0));
      img.push_back(b);
      sum = sum + b;
    end
`ifdef RV_BOOT_CHECKSUM_EN
    img.push_back(sum);
`endif
  endtask

  // Drives at #1 after posedge; a byte counts as taken when ready was high at the edge.
  task automatic send(input u8 s[$], input int max_gap, output int dropped);
    int gap;
    int t;
    bit acc;
    bit rdy;
    dropped = 0;
    foreach (s[i]) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) begin
        bus.rx_valid_i = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = s[i];
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 40) begin
        @(negedge clk);
        rdy = (bus.rx_ready_o === 1'b1);
        @(posedge clk);
        #1;
        acc = rdy;
        t++;
      end
      if (!acc) dropped++;
    end
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset          = 1'b1;
    bus.rx_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wr_q.delete();
    we_cyc_q.delete();
    dbl_we   = 1'b0;
    fall_cyc = -1;
  endtask

  task automatic run_img(input string tag, input u8 s[$], input int gap);
    int drop;
    do_reset();
    model(s);
    send(s, gap, drop);
    repeat (6) @(posedge clk);
    #1;
    check({tag, ".dropped"}, drop, 0);
    check({tag, ".nwrites"}, wr_q.size(), exp_w.size());
    foreach (exp_w[i]) begin
      if (i < wr_q.size()) check({tag, ".write"}, wr_q[i], {8'(i), exp_w[i]});
    end
    check({tag, ".done"},      bus.boot_done_o,  exp_run);
    check({tag, ".err"},       bus.boot_err_o,   exp_err);
    check({tag, ".core_rst"},  bus.core_reset_o, !exp_run);
    check({tag, ".ready"},     bus.rx_ready_o,   !(exp_run || exp_err));
    check({tag, ".single_we"}, dbl_we,           1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u8           s[$];
    logic [39:0] ref_q[$];
    int          drop;
    int          n;

    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;

    // Asynchronous reset values, applied between clock edges
    #2 reset = 1'b1;
    #1;
    check("rst.core_rst", bus.core_reset_o, 1'b1);
    check("rst.ready",    bus.rx_ready_o,   1'b0);
    check("rst.we",       bus.imem_we_o,    1'b0);
    check("rst.addr",     bus.imem_addr_o,  8'd0);
    check("rst.wdata",    bus.imem_wdata_o, 32'd0);
    check("rst.done",     bus.boot_done_o,  1'b0);
    check("rst.err",      bus.boot_err_o,   1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst.ready_pre_edge", bus.rx_ready_o, 1'b0);
    @(negedge clk);
    check("rst.ready_post_edge", bus.rx_ready_o, 1'b1);

    // Two-word reference image
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef RV_BOOT_CHECKSUM_EN
    s.push_back(8'hB6);
`endif
    run_img("two_word", s, 0);
    check("two_word.w0", wr_q.size() > 0 ? wr_q[0] : 40'h0, {8'd0, 32'h00000013});
    check("two_word.w1", wr_q.size() > 1 ? wr_q[1] : 40'h0, {8'd1, 32'h00100093});
`ifndef RV_BOOT_CHECKSUM_EN
    if (we_cyc_q.size() >= 2) check("two_word.core_fall", fall_cyc, we_cyc_q[1] + 1);
    else check("two_word.core_fall_nostrobe", we_cyc_q.size(), 2);
`endif

    // Bad lengths
    s = '{8'h00, 8'h00};
    run_img("len_zero", s, 0);
    s = '{8'h01, 8'h01};
    run_img("len_257", s, 0);
    s = '{8'h00, 8'h01};
`ifdef RV_BOOT_CHECKSUM_EN
    make_img(256);
    s = img;
`else
    make_img(256);
    s = img;
`endif
    run_img("len_256", s, 0);

`ifdef RV_BOOT_CHECKSUM_EN
    s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E};
    run_img("chk_good", s, 0);
    s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0F};
    run_img("chk_bad", s, 0);
    s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E};
    run_img("chk_good_gap", s, 3);
`endif

    // Back-to-back 8-word image, then a refused extra byte
    make_img(8);
    run_img("burst8", img, 0);
    check("burst8.nstrobe_cycles", we_cyc_q.size(), 8);
    for (int i = 1; i < we_cyc_q.size(); i++)
      check("burst8.spacing", we_cyc_q[i] - we_cyc_q[i-1], 4);
    s = '{8'h5A};
    send(s, 0, drop);
    check("burst8.extra_refused", drop, 1);
    check("burst8.no_extra_write", wr_q.size(), 8);

    // Reset mid-image, asserted off the clock edge
    make_img(2);
    s = img;
    do_reset();
    s = s[0:4];
    send(s, 0, drop);
    check("midrst.dropped", drop, 0);
    #3 reset = 1'b1;
    #1;
    check("midrst.core_rst", bus.core_reset_o, 1'b1);
    check("midrst.ready",    bus.rx_ready_o,   1'b0);
    check("midrst.we",       bus.imem_we_o,    1'b0);
    check("midrst.addr",     bus.imem_addr_o,  8'd0);
    check("midrst.wdata",    bus.imem_wdata_o, 32'd0);
    check("midrst.done",     bus.boot_done_o,  1'b0);
    check("midrst.err",      bus.boot_err_o,   1'b0);
    make_img(1);
    run_img("after_midrst", img, 0);

    // Random images, gap-free vs. random gaps
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(6, 1));
      make_img(n);
      s = img;
      run_img("rand_nogap", s, 0);
      ref_q = wr_q;
      run_img("rand_gap", s, 3);
      check("rand.same_count", wr_q.size(), ref_q.size());
      foreach (ref_q[i]) begin
        if (i < wr_q.size()) check("rand.same_word", wr_q[i], ref_q[i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_boot_loader.md
RV_BOOT_LOADER -- requirements
Module: rv_boot_loader

Interface
REQ-001 The block SHALL have parameter IMEM_DEPTH, default 256, meaning the instruction-memory depth in 32-bit words; ADDR_W SHALL be the localparam $clog2(IMEM_DEPTH).
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_valid_i  input  1  a byte is offered on rx_data_i.
REQ-005 rx_data_i  input  8  boot stream byte.
REQ-006 rx_ready_o  output  1  the loader can accept a byte.
REQ-007 imem_we_o  output  1  one-cycle instruction-memory write strobe.
REQ-008 imem_addr_o  output  ADDR_W  word address of the write.
REQ-009 imem_wdata_o  output  32  instruction word to write.
REQ-010 core_reset_o  output  1  active-high reset driven to the processor core; high holds the core in reset.
REQ-011 boot_done_o  output  1  the image is loaded and the core is released.
REQ-012 boot_err_o  output  1  the load failed (sticky).

Function
REQ-013 A byte SHALL be accepted only on a rising edge where rx_valid_i=1 and rx_ready_o=1; rx_valid_i while rx_ready_o=0 SHALL be ignored with no state change.
REQ-014 The FSM states SHALL be S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_RUN and S_ERR; S_LEN_LO is the reset state.
REQ-015 rx_ready_o SHALL be 1 in S_LEN_LO, S_LEN_HI, S_DATA and S_CHK, and 0 in S_RUN and S_ERR; the loader never back-pressures mid-image.
REQ-016 S_LEN_LO: the accepted byte SHALL be stored as N[7:0], and the FSM SHALL go to S_LEN_HI.
REQ-017 S_LEN_HI: the accepted byte SHALL be stored as N[15:8]; if N=0 or N>IMEM_DEPTH the FSM SHALL go to S_ERR, otherwise to S_DATA with the word counter at 0.
REQ-018 S_DATA: bytes SHALL be assembled little-endian (1st byte to bits 7:0, 4th byte to bits 31:24) using a 2-bit byte counter that wraps after 3.
REQ-019 The cycle after the 4th byte of a word is accepted, imem_we_o SHALL be 1 for exactly one cycle, with imem_addr_o equal to the word counter and imem_wdata_o equal to the assembled word; the word counter SHALL then increment.
REQ-020 When a byte is accepted during a write-strobe cycle, the loader SHALL assemble it without loss; one byte per cycle SHALL be sustainable.
REQ-021 On the write of word N-1, the FSM SHALL leave S_DATA in the same cycle, going to S_CHK when the checksum is enabled and to S_RUN otherwise.
REQ-022 On entry to S_RUN, core_reset_o SHALL be 0 and boot_done_o SHALL be 1 from the first S_RUN cycle onward, registered, with no glitches.
REQ-023 S_RUN and S_ERR SHALL be terminal until reset.
REQ-024 In S_ERR, core_reset_o SHALL be 1 and boot_err_o SHALL be 1.
REQ-025 imem_we_o SHALL be 0 in all states other than the write cycle of REQ-019.

Reset
REQ-026 On assertion of reset, regardless of the clock, outputs SHALL immediately take these values: core_reset_o=1, rx_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, boot_done_o=0, boot_err_o=0.
REQ-027 On assertion of reset, the FSM SHALL go to S_LEN_LO, and N, the counters and the checksum SHALL clear.
REQ-028 After reset deasserts, rx_ready_o SHALL go to 1 on the first clock edge.
REQ-029 Reset mid-load SHALL abandon the image; memory words already written SHALL not be cleared.

Configuration
REQ-030 With RV_BOOT_CHECKSUM_EN defined, an 8-bit modulo-256 sum of all data bytes, excluding the length bytes, SHALL be accumulated.
REQ-031 With RV_BOOT_CHECKSUM_EN defined, the byte accepted in S_CHK SHALL be compared with the sum: a match SHALL go to S_RUN and a mismatch to S_ERR.
REQ-032 Without RV_BOOT_CHECKSUM_EN, S_CHK and the accumulator SHALL be absent, and S_DATA SHALL go directly to S_RUN.

Structure
REQ-033 Package rv_boot_pkg SHALL hold the state enum typedef, the 16-bit length typedef and the default IMEM_DEPTH constant.
REQ-034 Sub-module rv_boot_word_asm (byte-to-word assembler with byte counter and word-ready pulse) SHALL be instantiated once; the FSM and counters stay in rv_boot_loader.

Verification
REQ-035 Stream 02 00 13 00 00 00 93 00 10 00, no checksum build -> writes addr0=0x00000013 and addr1=0x00100093, one strobe each; core_reset_o falls one cycle after the 2nd strobe; boot_done_o=1.
REQ-036 Length bytes 00 00, and separately 01 01 (257) with IMEM_DEPTH=256 -> S_ERR, boot_err_o=1, core_reset_o stays 1, no imem_we_o.
REQ-037 Checksum build, one word AA BB CC DD then checksum 0x0E -> S_RUN; the same word with checksum 0x0F -> S_ERR with the word still written at addr0.
REQ-038 rx_valid_i held 1 continuously for an 8-word image -> 8 strobes spaced 4 cycles apart, no dropped bytes; after S_RUN extra bytes are refused (rx_ready_o=0).
REQ-039 Reset asserted mid-image after 5 bytes -> outputs immediately at reset values; a subsequent full 1-word image loads to addr0 correctly.
REQ-040 rx_valid_i toggled with random gaps (0-3 idle cycles) -> the written words are identical to the gap-free run.
